// File: rtl/afe_spi_pkg.sv
// Shared types and elaboration-time helpers for the AFE SPI writer.
package afe_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LATCH,
    ST_GUARD
  } state_t;

  // Half SPI period in sysClk cycles: ceil(clk / (2*spi)), never below 1.
  function automatic int half_div(input longint clk_rate, input longint spi_rate);
    longint h;
    h = (clk_rate + 2 * spi_rate - 1) / (2 * spi_rate);
    if (h < 1) h = 1;
    return int'(h);
  endfunction

  // Bits needed to index n items, with a floor of one bit (channel select, counters).
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afe_spi_tick.sv
// Half-period divider: one-cycle tick every HALF_DIV cycles, restarted from zero by i_clear.
module afe_spi_tick
  import afe_spi_pkg::*;
#(
  parameter int HALF_DIV = 1
) (
  input  logic sysClk,
  input  logic sysReset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = clog2_min1(HALF_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge sysClk) begin
    if (sysReset || i_clear) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/afe_spi_writer.sv
// Write-only 3-wire AFE SPI serialiser with latch pulse, one bus selected per command.
// Optional per-bus shadow of the last latched word when AFE_SPI_SHADOW_EN is defined.
module afe_spi_writer
  import afe_spi_pkg::*;
#(
  parameter int CLK_RATE      = 99999001,
  parameter int SPI_RATE      = 1000000,
  parameter int DATA_WIDTH    = 16,
  parameter int CHANNEL_COUNT = 2,
  localparam int CW           = clog2_min1(CHANNEL_COUNT)
) (
  input  logic                     sysClk,
  input  logic                     sysReset,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic [CW-1:0]            cmdChannel,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic                     cmdError,
  output logic                     busy,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
  output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
`ifdef AFE_SPI_SHADOW_EN
  ,
  output logic [CHANNEL_COUNT*DATA_WIDTH-1:0] shadowData
`endif
);

  localparam int H_DIV = half_div(CLK_RATE, SPI_RATE);
  localparam int BW    = clog2_min1(DATA_WIDTH);
  localparam logic [CW:0]   CH_LIMIT = (CW + 1)'(CHANNEL_COUNT);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_chan;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit;
  logic                  r_phase;
  logic                  r_error;

  logic w_tick;
  logic w_clear;
  logic w_accept;
  logic w_bad_chan;
  logic w_start;
  logic w_clk;
  logic w_sdi;
  logic w_le;

  assign cmdReady   = (r_state == ST_IDLE) & ~sysReset;
  assign busy       = (r_state != ST_IDLE) & ~sysReset;
  assign cmdError   = r_error;
  assign w_accept   = cmdValid & cmdReady;
  assign w_bad_chan = ({1'b0, cmdChannel} >= CH_LIMIT);
  assign w_start    = w_accept & ~w_bad_chan;
  // Divider restarts on every state entry so each phase lasts exactly H_DIV cycles.
  assign w_clear    = (r_state == ST_IDLE) | (w_state_next != r_state);

  afe_spi_tick #(.HALF_DIV(H_DIV)) u_tick (
    .sysClk  (sysClk),
    .sysReset(sysReset),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && r_phase && (r_bit == LAST_BIT)) w_state_next = ST_GAP;
      ST_GAP:   if (w_tick) w_state_next = ST_LATCH;
      ST_LATCH: if (w_tick) w_state_next = ST_GUARD;
      ST_GUARD: if (w_tick) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      r_state <= ST_IDLE;
      r_chan  <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_phase <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_error <= w_accept & w_bad_chan;
      if (w_start) begin
        r_chan  <= cmdChannel;
        r_shift <= cmdData;
        r_bit   <= '0;
        r_phase <= 1'b0;
      end else if ((r_state == ST_SHIFT) && w_tick) begin
        r_phase <= ~r_phase;
        if (r_phase) begin
          // Last bit stays in the MSB so SDI holds it through GAP.
          if (r_bit == LAST_BIT) begin
            r_bit <= '0;
          end else begin
            r_bit   <= r_bit + 1'b1;
            r_shift <= r_shift << 1;
          end
        end
      end
    end
  end

  always_comb begin
    w_clk = 1'b0;
    w_sdi = 1'b0;
    w_le  = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        w_clk = r_phase;
        w_sdi = r_shift[DATA_WIDTH-1];
      end
      ST_GAP:   w_sdi = r_shift[DATA_WIDTH-1];
      ST_LATCH: w_le  = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    AFE_SPI_CLK = '0;
    AFE_SPI_SDI = '0;
    AFE_SPI_LE  = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (r_chan == CW'(i)) begin
        AFE_SPI_CLK[i] = w_clk;
        AFE_SPI_SDI[i] = w_sdi;
        AFE_SPI_LE[i]  = w_le;
      end
    end
  end

`ifdef AFE_SPI_SHADOW_EN
  logic [DATA_WIDTH-1:0]               r_word;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] r_shadow;

  // NOTE: the shadow bank is reset because its contents are visible to software right after reset.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      r_word   <= '0;
      r_shadow <= '0;
    end else begin
      if (w_start) r_word <= cmdData;
      if ((r_state == ST_LATCH) && w_tick) begin
        r_shadow[int'(r_chan)*DATA_WIDTH +: DATA_WIDTH] <= r_word;
      end
    end
  end

  assign shadowData = r_shadow;
`endif

endmodule

// File: tb/tb_afe_spi_writer.sv
// Self-checking bench: cycle-level waveform model derived from the transfer timeline plus a pin decoder.
module tb_afe_spi_writer;

  localparam int DW    = 16;
  localparam int NCH   = 3;
  localparam int H     = 4;
  localparam int TOTAL = (2 * DW + 3) * H;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] word;
  } xfer_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic [1:0]        chan = '0;
  logic [DW-1:0]     data = '0;
  logic              ready;
  logic              err;
  logic              busy_o;
  logic [NCH-1:0]    spi_clk;
  logic [NCH-1:0]    spi_sdi;
  logic [NCH-1:0]    spi_le;
  logic [NCH*DW-1:0] shadow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int            cyc = 0;
  bit            m_active = 1'b0;
  int            m_t0 = 0;
  logic [DW-1:0] m_word = '0;
  int            m_ch = 0;
  bit            m_err = 1'b0;
  int            m_acc = 0;
  int            m_done = 0;
  logic [NCH*DW-1:0] m_shadow = '0;
  xfer_t         exp_q[$];

  // Pin decoder state.
  logic [DW-1:0] cap[NCH];
  int            edges[NCH];
  int            le_len[NCH];
  logic [NCH-1:0] p_clk = '0;
  logic [NCH-1:0] p_le = '0;
  int            n_le_falls = 0;
  logic [NCH-1:0] e_clk, e_sdi, e_le;

  afe_spi_writer #(
    .CLK_RATE     (8),
    .SPI_RATE     (1),
    .DATA_WIDTH   (DW),
    .CHANNEL_COUNT(NCH)
  ) dut (
    .sysClk     (clk),
    .sysReset   (rst),
    .cmdValid   (valid),
    .cmdReady   (ready),
    .cmdChannel (chan),
    .cmdData    (data),
    .cmdError   (err),
    .busy       (busy_o),
    .AFE_SPI_CLK(spi_clk),
    .AFE_SPI_SDI(spi_sdi),
    .AFE_SPI_LE (spi_le)
`ifdef AFE_SPI_SHADOW_EN
    ,
    .shadowData (shadow)
`endif
  );

`ifndef AFE_SPI_SHADOW_EN
  assign shadow = '0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected pins for offset k (1-based) into a transfer: bits, gap, latch, guard.
  function automatic void exp_pins(input bit act, input int k, input logic [DW-1:0] w, input int ch,
                                   output logic [NCH-1:0] c, output logic [NCH-1:0] s,
                                   output logic [NCH-1:0] l);
    int bi;
    c = '0;
    s = '0;
    l = '0;
    if (act && k >= 1) begin
      if (k <= 2 * DW * H) begin
        bi    = (k - 1) / (2 * H);
        c[ch] = ((k - 1) % (2 * H)) >= H;
        s[ch] = w[DW-1-bi];
      end else if (k <= (2 * DW + 1) * H) begin
        s[ch] = w[0];
      end else if (k <= (2 * DW + 2) * H) begin
        l[ch] = 1'b1;
      end
    end
  endfunction

  // Model: advances one sysClk edge using the inputs held through the previous cycle.
  always @(posedge clk) begin
    bit was_idle;
    xfer_t t;
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_err    = 1'b0;
      m_shadow = '0;
      exp_q.delete();
    end else begin
      was_idle = !m_active;
      m_err    = 1'b0;
      if (m_active && cyc == m_t0 + (2 * DW + 2) * H) m_shadow[m_ch*DW +: DW] = m_word;
      if (m_active && cyc == m_t0 + TOTAL) begin
        m_active = 1'b0;
        m_done++;
      end
      if (was_idle && valid) begin
        if (int'(chan) >= NCH) begin
          m_err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_t0     = cyc;
          m_word   = data;
          m_ch     = int'(chan);
          t.ch     = chan;
          t.word   = data;
          exp_q.push_back(t);
          m_acc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    xfer_t t;
    if (cyc > 0) begin
      exp_pins(m_active, cyc - m_t0 + 1, m_word, m_ch, e_clk, e_sdi, e_le);
      check("spi_clk", spi_clk, e_clk);
      check("spi_sdi", spi_sdi, e_sdi);
      check("spi_le", spi_le, e_le);
      check("cmd_ready", ready, !m_active && !rst);
      check("busy", busy_o, m_active && !rst);
      check("cmd_error", err, m_err);
`ifdef AFE_SPI_SHADOW_EN
      check("shadow", shadow, m_shadow);
`endif
      for (int b = 0; b < NCH; b++) begin
        if (rst) begin
          cap[b]    = '0;
          edges[b]  = 0;
          le_len[b] = 0;
        end else begin
          if (spi_clk[b] && !p_clk[b]) begin
            cap[b] = {cap[b][DW-2:0], spi_sdi[b]};
            edges[b]++;
          end
          if (spi_le[b]) begin
            le_len[b]++;
          end else if (p_le[b]) begin
            n_le_falls++;
            check("le_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              t = exp_q.pop_front();
              check("le_bus", b, t.ch);
              check("le_word", cap[b], t.word);
            end
            check("le_edges", edges[b], DW);
            check("le_width", le_len[b], H);
            cap[b]    = '0;
            edges[b]  = 0;
            le_len[b] = 0;
          end
        end
      end
      p_clk = spi_clk;
      p_le  = spi_le;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [DW-1:0] d);
    int acc0;
    int n;
    acc0  = m_acc;
    n     = 0;
    valid = 1'b1;
    chan  = ch;
    data  = d;
    step();
    while (m_acc == acc0 && !m_err && n < 400) begin
      step();
      n++;
    end
    valid = 1'b0;
    if (!m_err) check("accept_timeout", m_acc - acc0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_active && n < 400) begin
      step();
      n++;
    end
    check("idle_timeout", m_active, 0);
  endtask

  initial begin
    int n;
    logic [1:0] rch;
    for (int b = 0; b < NCH; b++) begin
      cap[b]    = '0;
      edges[b]  = 0;
      le_len[b] = 0;
    end

    repeat (3) step();
    check("reset_ready", ready, 0);
    check("reset_busy", busy_o, 0);
    check("reset_pins", {spi_clk, spi_sdi, spi_le}, 0);
    rst = 1'b0;
    step();
    check("ready_after_reset", ready, 1);

    // Single transfer, busy length measured on the pin.
    send(2'd0, 16'hA5C3);
    n = 0;
    while (busy_o && n < 1000) begin
      n++;
      step();
    end
    check("busy_cycles", n, TOTAL);
    check("ready_after_xfer", ready, 1);

    send(2'd0, 16'h1234);
    wait_idle();
`ifdef AFE_SPI_SHADOW_EN
    check("shadow_1234", shadow[DW-1:0], 16'h1234);
`endif

    // Back-to-back: second command waits with valid high and goes on the first ready cycle.
    send(2'd1, 16'h0001);
    send(2'd0, 16'hFFFF);
    wait_idle();

    // Out-of-range channel.
    send(2'd3, 16'hBEEF);
    check("error_pulse", err, 1);
    check("error_ready", ready, 1);
    step();
    check("error_clear", err, 0);

    // Valid held during busy with changing data.
    send(2'd2, 16'hC0DE);
    valid = 1'b1;
    repeat (60) begin
      chan = 2'($urandom_range(0, 2));
      data = 16'($urandom);
      step();
    end
    valid = 1'b0;
    wait_idle();

    // Reset during bit 7.
    send(2'd0, 16'h5A3C);
    repeat (7 * 2 * H + 1) step();
    rst = 1'b1;
    step();
    check("abort_pins", {spi_clk, spi_sdi, spi_le}, 0);
    check("abort_busy", busy_o, 0);
    step();
    rst = 1'b0;
    step();
    check("abort_ready", ready, 1);

    // Randomised traffic.
    for (int i = 0; i < 20; i++) begin
      rch = 2'($urandom_range(0, 3));
      send(rch, 16'($urandom));
      if (rch != 2'd3 && $urandom_range(0, 1) == 1) begin
        valid = 1'b1;
        repeat (20) begin
          chan = 2'($urandom);
          data = 16'($urandom);
          step();
        end
        valid = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    check("completed", n_le_falls, m_done);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
